// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Tracks register tags through EX, MEM and WB and steers the EX operand bypass muxes.

module fwd_sel_unit #(
    parameter int RA_W = 5
) (
    input  logic            ex_v,
    input  logic            ex_use,
    input  logic [RA_W-1:0] ex_src,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_wr,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_wr,
    output logic [1:0]      sel
);
    logic hit_mem, hit_wb;

    assign hit_mem = ex_v && ex_use && mem_we && (mem_wr != '0) && (mem_wr == ex_src);
    assign hit_wb  = ex_v && ex_use && wb_we  && (wb_wr  != '0) && (wb_wr  == ex_src);

    // The youngest producer (EX/MEM) takes precedence over MEM/WB.
    always_comb begin
        sel = 2'b00;
        if (hit_mem)
            sel = 2'b10;
        else if (hit_wb)
            sel = 2'b01;
    end
endmodule

module fwd_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_wr_reg,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_busy,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            use_rs;
        logic            use_rt;
        logic            we;
        logic [RA_W-1:0] wr;
        logic            ld;
    } ex_t;

    typedef struct packed {
        logic            we;
        logic [RA_W-1:0] wr;
        logic            ld;
    } mem_t;

    typedef struct packed {
        logic            we;
        logic [RA_W-1:0] wr;
    } wb_t;

    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;

    logic lu;
    logic cnt_inc;

    logic [NUM_OPS-1:0][RA_W-1:0] ex_src;
    logic [NUM_OPS-1:0]           ex_use;
    logic [NUM_OPS-1:0][1:0]      sel;

    assign ex_src = {ex_q.rt, ex_q.rs};
    assign ex_use = {ex_q.use_rt, ex_q.use_rs};

    generate
        for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
            fwd_sel_unit #(.RA_W(RA_W)) u_sel (
                .ex_v   (ex_q.v),
                .ex_use (ex_use[i]),
                .ex_src (ex_src[i]),
                .mem_we (mem_q.we),
                .mem_wr (mem_q.wr),
                .wb_we  (wb_q.we),
                .wb_wr  (wb_q.wr),
                .sel    (sel[i])
            );
        end
    endgenerate

    assign fwd_sel_a = sel[0];
    assign fwd_sel_b = sel[1];

    assign lu = id_valid && ex_q.v && ex_q.ld && ex_q.we && (ex_q.wr != '0) &&
                ((id_use_rs && (id_rs == ex_q.wr)) || (id_use_rt && (id_rt == ex_q.wr)));

    // A frozen memory stage outranks a taken branch, which in turn squashes the
    // dependent instruction so no load-use stall is needed.
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        cnt_inc     = 1'b0;
        if (mem_busy) begin
            stall_if_id = 1'b1;
        end else if (flush) begin
            bubble_ex   = 1'b1;
        end else if (lu) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
            cnt_inc     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else if (!mem_busy) begin
            wb_q.we   <= mem_q.we;
            wb_q.wr   <= mem_q.wr;
            mem_q.we  <= ex_q.v && ex_q.we;
            mem_q.wr  <= ex_q.wr;
            mem_q.ld  <= ex_q.v && ex_q.ld;
            if (bubble_ex) begin
                ex_q <= '0;
            end else begin
                ex_q.v      <= id_valid;
                ex_q.rs     <= id_rs;
                ex_q.rt     <= id_rt;
                ex_q.use_rs <= id_use_rs;
                ex_q.use_rt <= id_use_rt;
                ex_q.we     <= id_wr_en;
                ex_q.wr     <= id_wr_reg;
                ex_q.ld     <= id_is_load;
            end
            if (cnt_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
